// File: rtl/el2_trace_serializer_pkg.sv
// Shared types for the trace serializer: trace packet layout, FIFO entry,
// record header layout and the output FSM state encoding.
package el2_trace_serializer_pkg;

  typedef struct packed {
    logic [31:0] insn_ip;
    logic [31:0] address_ip;
    logic        valid_ip;
    logic        exception_ip;
    logic [4:0]  ecause_ip;
    logic        interrupt_ip;
    logic [31:0] tval_ip;
  } el2_trace_pkt_t;

  typedef struct packed {
    logic [15:0] seq;
    logic        rsvd;
    logic [5:0]  pend_drop;
    logic        has_tval;
    logic [4:0]  ecause;
    logic        interrupt;
    logic        exception;
    logic        valid;
  } el2_trace_rec_hdr_t;

  typedef struct packed {
    el2_trace_pkt_t pkt;
    logic [15:0]    seq;
    logic [5:0]     pend_drop;
  } el2_trace_ent_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ADDR = 3'd2,
    INSN = 3'd3,
    TVAL = 3'd4
  } el2_trace_ser_state_t;

  localparam int TRACE_DROP_SAT = 63;

  function automatic logic [31:0] trace_hdr(input el2_trace_ent_t e);
    el2_trace_rec_hdr_t h;
    h.seq       = e.seq;
    h.rsvd      = 1'b0;
    h.pend_drop = e.pend_drop;
    h.has_tval  = e.pkt.exception_ip | e.pkt.interrupt_ip;
    h.ecause    = e.pkt.ecause_ip;
    h.interrupt = e.pkt.interrupt_ip;
    h.exception = e.pkt.exception_ip;
    h.valid     = e.pkt.valid_ip;
    return h;
  endfunction

endpackage

// File: rtl/el2_trace_fifo.sv
// Record FIFO. A push while full is accepted only when the head is popped in
// the same cycle (the freed slot is the one being written). Exposes the head
// entry plus the header of the entry behind it so the serializer can start
// the next record without a bubble.
module el2_trace_fifo
  import el2_trace_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           push,
  input  el2_trace_ent_t wdata,
  input  logic           pop,
  output el2_trace_ent_t head,
  output logic [31:0]    next_hdr,
  output logic           empty,
  output logic           full,
  output logic           more_than_one
);

  localparam int AW = $clog2(DEPTH);

  el2_trace_ent_t mem [DEPTH];
  logic [AW:0]    wr_q, rd_q, cnt;
  logic [AW-1:0]  rd_idx_nxt;
  logic           wr_en, rd_en;

  assign empty         = (wr_q == rd_q);
  assign full          = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign cnt           = wr_q - rd_q;
  assign more_than_one = (cnt > (AW+1)'(1));
  assign wr_en         = push & (~full | pop);
  assign rd_en         = pop & ~empty;
  assign rd_idx_nxt    = rd_q[AW-1:0] + AW'(1);
  assign head          = mem[rd_q[AW-1:0]];
  assign next_hdr      = trace_hdr(mem[rd_idx_nxt]);

  // Pointer update; wrap bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + (AW+1)'(1);
      if (rd_en) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/el2_trace_serializer.sv
// Trace serializer: captures qualifying trace packets into a FIFO and emits
// each as HDR/ADDR/INSN[/TVAL] words on a registered valid/ready stream.
// Dropped packets are counted and reported in the next stored header.
module el2_trace_serializer
  import el2_trace_serializer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           trace_en,
  input  el2_trace_pkt_t trace_pkt,
  output logic           tr_valid,
  output logic [31:0]    tr_data,
  output logic           tr_last,
  input  logic           tr_ready,
  output logic           fifo_empty,
  output logic [15:0]    drop_total
);

  el2_trace_ser_state_t state_q, state_d;
  el2_trace_ent_t       wdata, head;
  logic [31:0]          next_hdr, data_d;
  logic [SEQ_W-1:0]     seq_q;
  logic [5:0]           pend_q;
  logic                 cap, push, pop, drop, advance, head_tval;
  logic                 f_empty, f_full, f_more, valid_d, last_d;

  assign cap       = trace_en & (trace_pkt.valid_ip | trace_pkt.exception_ip | trace_pkt.interrupt_ip);
  assign pop       = tr_valid & tr_ready & tr_last;
  assign push      = cap & (~f_full | pop);
  assign drop      = cap & f_full & ~pop;
  assign advance   = ~tr_valid | tr_ready;
  assign head_tval = head.pkt.exception_ip | head.pkt.interrupt_ip;

  assign wdata.pkt       = trace_pkt;
  assign wdata.seq       = 16'(seq_q);
  assign wdata.pend_drop = pend_q;

  assign fifo_empty = f_empty & (state_q == IDLE);

  el2_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_l        (rst_l),
    .push         (push),
    .wdata        (wdata),
    .pop          (pop),
    .head         (head),
    .next_hdr     (next_hdr),
    .empty        (f_empty),
    .full         (f_full),
    .more_than_one(f_more)
  );

  // Next word selection; an idle serializer loads the incoming packet's
  // header directly so it appears the cycle after capture.
  always_comb begin
    state_d = state_q;
    valid_d = tr_valid;
    data_d  = tr_data;
    last_d  = tr_last;
    if (advance) begin
      case (state_q)
        IDLE: begin
          if (!f_empty) begin
            state_d = HDR; valid_d = 1'b1; data_d = trace_hdr(head); last_d = 1'b0;
          end else if (push) begin
            state_d = HDR; valid_d = 1'b1; data_d = trace_hdr(wdata); last_d = 1'b0;
          end
        end
        HDR: begin
          state_d = ADDR; data_d = head.pkt.address_ip; last_d = 1'b0;
        end
        ADDR: begin
          state_d = INSN; data_d = head.pkt.insn_ip; last_d = ~head_tval;
        end
        INSN, TVAL: begin
          if (state_q == INSN && head_tval) begin
            state_d = TVAL; data_d = head.pkt.tval_ip; last_d = 1'b1;
          end else if (f_more) begin
            state_d = HDR; valid_d = 1'b1; data_d = next_hdr; last_d = 1'b0;
          end else begin
            state_d = IDLE; valid_d = 1'b0; data_d = '0; last_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE; valid_d = 1'b0; data_d = '0; last_d = 1'b0;
        end
      endcase
    end
  end

  // Output register and FSM state.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      tr_valid <= 1'b0;
      tr_data  <= '0;
      tr_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tr_valid <= valid_d;
      tr_data  <= data_d;
      tr_last  <= last_d;
    end
  end

  // Sequence number, pending-drop and total-drop counters.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      seq_q      <= '0;
      pend_q     <= '0;
      drop_total <= '0;
    end else begin
      if (push) begin
        seq_q  <= seq_q + SEQ_W'(1);
        pend_q <= '0;
      end else if (drop && pend_q != 6'(TRACE_DROP_SAT)) begin
        pend_q <= pend_q + 6'd1;
      end
      if (drop && drop_total != 16'hFFFF) drop_total <= drop_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_el2_trace_serializer.sv
// Directed bench for el2_trace_serializer: a vector table for the basic
// record formats followed by hand-written backpressure, overflow,
// full-with-pop and reset sequences.
module tb_el2_trace_serializer;
  import el2_trace_serializer_pkg::*;

  logic           clk = 1'b0;
  logic           rst_l;
  logic           trace_en;
  el2_trace_pkt_t trace_pkt;
  logic           tr_valid, tr_last, tr_ready, fifo_empty;
  logic [31:0]    tr_data;
  logic [15:0]    drop_total;

  int errors = 0;
  int checks = 0;

  el2_trace_serializer #(.DEPTH(4), .SEQ_W(16)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .trace_en  (trace_en),
    .trace_pkt (trace_pkt),
    .tr_valid  (tr_valid),
    .tr_data   (tr_data),
    .tr_last   (tr_last),
    .tr_ready  (tr_ready),
    .fifo_empty(fifo_empty),
    .drop_total(drop_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, vld, exc, intr;
    logic [4:0]  ecause;
    logic [31:0] addr, insn, tval;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last, e_empty;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic en, logic vld, logic exc, logic intr, logic [4:0] ec,
                              logic [31:0] a, logic [31:0] i, logic [31:0] t,
                              logic ev, logic [31:0] ed, logic el, logic ee, logic [15:0] edr);
    vec_t v;
    v.en = en; v.vld = vld; v.exc = exc; v.intr = intr; v.ecause = ec;
    v.addr = a; v.insn = i; v.tval = t;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_empty = ee; v.e_drop = edr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic vld, input logic exc, input logic intr,
                       input logic [4:0] ec, input logic [31:0] a, input logic [31:0] i,
                       input logic [31:0] t);
    trace_en               = en;
    trace_pkt.valid_ip     = vld;
    trace_pkt.exception_ip = exc;
    trace_pkt.interrupt_ip = intr;
    trace_pkt.ecause_ip    = ec;
    trace_pkt.address_ip   = a;
    trace_pkt.insn_ip      = i;
    trace_pkt.tval_ip      = t;
  endtask

  task automatic idle_in();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic exp_word(input string nm, input logic [31:0] d, input logic l);
    chk({nm, ".valid"}, 32'(tr_valid), 32'd1);
    chk({nm, ".data"}, tr_data, d);
    chk({nm, ".last"}, 32'(tr_last), 32'(l));
  endtask

  task automatic do_reset();
    idle_in();
    tr_ready = 1'b1;
    rst_l = 1'b0;
    #1;
    step();
    rst_l = 1'b1;
    chk("rst.valid", 32'(tr_valid), 32'd0);
    chk("rst.empty", 32'(fifo_empty), 32'd1);
    chk("rst.drop", 32'(drop_total), 32'd0);
  endtask

  initial begin
    rst_l    = 1'b0;
    tr_ready = 1'b1;
    idle_in();

    vecs[0]  = mk(1,1,0,0,5'd0,32'h8000_0010,32'h00A0_0093,32'h0, 1,32'h0000_0001,0,0,0);
    vecs[1]  = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h8000_0010,0,0,0);
    vecs[2]  = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h00A0_0093,1,0,0);
    vecs[3]  = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 0,32'h0,0,1,0);
    vecs[4]  = mk(1,0,1,0,5'd2,32'h8000_0020,32'h0000_0073,32'hDEAD_BEEF, 1,32'h0001_0112,0,0,0);
    vecs[5]  = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h8000_0020,0,0,0);
    vecs[6]  = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h0000_0073,0,0,0);
    vecs[7]  = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'hDEAD_BEEF,1,0,0);
    vecs[8]  = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 0,32'h0,0,1,0);
    vecs[9]  = mk(1,0,0,1,5'd5,32'h8000_0100,32'h3020_0073,32'h0000_000B, 1,32'h0002_012C,0,0,0);
    vecs[10] = mk(1,1,0,0,5'd0,32'h8000_0104,32'h0010_0113,32'h0, 1,32'h8000_0100,0,0,0);
    vecs[11] = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h3020_0073,0,0,0);
    vecs[12] = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h0000_000B,1,0,0);
    vecs[13] = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h0003_0001,0,0,0);
    vecs[14] = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h8000_0104,0,0,0);
    vecs[15] = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 1,32'h0010_0113,1,0,0);
    vecs[16] = mk(1,0,0,0,5'd0,32'h0,32'h0,32'h0,                 0,32'h0,0,1,0);
    vecs[17] = mk(0,1,0,0,5'd0,32'h9000_0000,32'h13,32'h0,        0,32'h0,0,1,0);
    vecs[18] = mk(1,0,0,0,5'd7,32'h9000_0004,32'h13,32'h0,        0,32'h0,0,1,0);

    // Reset values
    #3;
    chk("reset.valid", 32'(tr_valid), 32'd0);
    chk("reset.data", tr_data, 32'h0);
    chk("reset.last", 32'(tr_last), 32'd0);
    chk("reset.empty", 32'(fifo_empty), 32'd1);
    chk("reset.drop", 32'(drop_total), 32'd0);
    step();
    step();
    rst_l = 1'b1;

    // Vector table, sink always ready
    for (int k = 0; k < 19; k++) begin
      drive(vecs[k].en, vecs[k].vld, vecs[k].exc, vecs[k].intr, vecs[k].ecause,
            vecs[k].addr, vecs[k].insn, vecs[k].tval);
      step();
      chk($sformatf("vec%0d.valid", k), 32'(tr_valid), 32'(vecs[k].e_valid));
      chk($sformatf("vec%0d.data", k), tr_data, vecs[k].e_data);
      chk($sformatf("vec%0d.last", k), 32'(tr_last), 32'(vecs[k].e_last));
      chk($sformatf("vec%0d.empty", k), 32'(fifo_empty), 32'(vecs[k].e_empty));
      chk($sformatf("vec%0d.drop", k), 32'(drop_total), 32'(vecs[k].e_drop));
    end

    // Backpressure: stall for 5 cycles on the ADDR word
    drive(1,1,0,0,5'd0,32'h8000_0200,32'h0020_0193,32'h0);
    step();
    idle_in();
    exp_word("bp.hdr", 32'h0004_0001, 1'b0);
    step();
    exp_word("bp.addr", 32'h8000_0200, 1'b0);
    tr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      exp_word($sformatf("bp.hold%0d", c), 32'h8000_0200, 1'b0);
    end
    tr_ready = 1'b1;
    step();
    exp_word("bp.insn", 32'h0020_0193, 1'b1);
    step();
    chk("bp.idle", 32'(tr_valid), 32'd0);
    chk("bp.empty", 32'(fifo_empty), 32'd1);

    // Overflow: 7 packets into a stalled 4-deep FIFO
    do_reset();
    tr_ready = 1'b0;
    for (int p = 0; p < 7; p++) begin
      drive(1,1,0,0,5'd0,32'h1000 + 32'(p*4),32'(p),32'h0);
      step();
    end
    idle_in();
    chk("ovf.drop", 32'(drop_total), 32'd3);
    exp_word("ovf.hold", 32'h0000_0001, 1'b0);
    tr_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_word($sformatf("ovf.r%0d.hdr", r), {16'(r), 16'h0001}, 1'b0);
      step();
      exp_word($sformatf("ovf.r%0d.addr", r), 32'h1000 + 32'(r*4), 1'b0);
      step();
      exp_word($sformatf("ovf.r%0d.insn", r), 32'(r), 1'b1);
      step();
    end
    chk("ovf.drained", 32'(fifo_empty), 32'd1);
    drive(1,1,0,0,5'd0,32'h2000,32'h13,32'h0);
    step();
    idle_in();
    exp_word("ovf.pend3", 32'h0004_0601, 1'b0);
    step(); step(); step();
    drive(1,1,0,0,5'd0,32'h2004,32'h13,32'h0);
    step();
    idle_in();
    exp_word("ovf.pend0", 32'h0005_0001, 1'b0);
    chk("ovf.drop_keep", 32'(drop_total), 32'd3);
    step(); step(); step();

    // Full FIFO: capture coincides with the final-word handshake
    do_reset();
    tr_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      drive(1,1,0,0,5'd0,32'h3000 + 32'(p*4),32'h100 + 32'(p),32'h0);
      step();
    end
    idle_in();
    tr_ready = 1'b1;
    step();
    step();
    exp_word("fp.insn0", 32'h0000_0100, 1'b1);
    drive(1,1,0,0,5'd0,32'h3010,32'h104,32'h0);
    step();
    idle_in();
    chk("fp.nodrop", 32'(drop_total), 32'd0);
    for (int r = 1; r < 5; r++) begin
      exp_word($sformatf("fp.r%0d.hdr", r), {16'(r), 16'h0001}, 1'b0);
      step();
      exp_word($sformatf("fp.r%0d.addr", r), 32'h3000 + 32'(r*4), 1'b0);
      step();
      exp_word($sformatf("fp.r%0d.insn", r), 32'h100 + 32'(r), 1'b1);
      step();
    end
    chk("fp.empty", 32'(fifo_empty), 32'd1);

    // Reset while a record is in flight
    drive(1,1,0,0,5'd0,32'h4000,32'h13,32'h0);
    step();
    idle_in();
    step();
    exp_word("mr.addr", 32'h0000_4000, 1'b0);
    #2;
    rst_l = 1'b0;
    #1;
    chk("mr.valid", 32'(tr_valid), 32'd0);
    chk("mr.data", tr_data, 32'h0);
    chk("mr.empty", 32'(fifo_empty), 32'd1);
    step();
    rst_l = 1'b1;
    drive(1,1,0,0,5'd0,32'h5000,32'h13,32'h0);
    step();
    idle_in();
    exp_word("mr.hdr", 32'h0000_0001, 1'b0);
    chk("mr.drop", 32'(drop_total), 32'd0);
    step(); step(); step();
    chk("mr.end_empty", 32'(fifo_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/el2_trace_serializer.md
Name: el2_trace_serializer

Overview:
- Consumer end of the core's per-retirement trace packet (el2_trace_pkt_t).
- Captures each qualifying retire, exception or interrupt packet into a small FIFO.
- Emits each as a 3- or 4-word record on a 32-bit valid/ready stream toward an off-core trace sink/port.
- Sits between the decode/TLU trace outputs and the SoC trace fabric; drops are counted, never stall the core.

Parameters:
DEPTH, 4, FIFO entries (records); power of 2, >=2
SEQ_W, 16, record sequence counter width (fixed 16 in header)

Ports:
clk  input  1  core clock
rst_l  input  1  asynchronous active-low reset
trace_en  input  1  capture enable (sampled per cycle)
trace_pkt  input  104  el2_trace_pkt_t from core, new packet every cycle
tr_valid  output  1  stream word valid
tr_data  output  32  stream word
tr_last  output  1  final word of current record
tr_ready  input  1  sink accepts word when tr_valid & tr_ready
fifo_empty  output  1  no records pending or in flight
drop_total  output  16  saturating count of dropped packets since reset

Behaviour:
- Interface: one clock, clk; reset rst_l is asynchronous, active-low.
- Reset values: tr_valid=0, tr_data=0, tr_last=0, fifo_empty=1, drop_total=0; FIFO pointers, seq counter, pending-drop counter and FSM (IDLE) cleared; a partially sent record is discarded.
- Capture qualifier: cap = trace_en & (valid_ip | exception_ip | interrupt_ip).
- Push: on cap, if FIFO not full, or full and a pop occurs this cycle, store {pkt, seq, pend_drop}.
  - seq increments, wrapping 0xFFFF->0x0000.
  - pend_drop clears to 0.
- Drop: on cap with FIFO full and no same-cycle pop, packet is discarded.
  - pend_drop increments, saturating at 63.
  - drop_total increments, saturating at 0xFFFF.
- Pop: occurs when the final word of the head record is accepted (tr_valid & tr_ready & tr_last).
- Header word [31:0]:
  - [0] valid_ip, [1] exception_ip, [2] interrupt_ip, [7:3] ecause
  - [8] has_tval = exception_ip | interrupt_ip
  - [14:9] pend_drop, [15] 0, [31:16] seq
- Record sequence: HDR, ADDR (address_ip), INSN (insn_ip), then TVAL (tval_ip) only if has_tval. tr_last is set on INSN when !has_tval, otherwise on TVAL.
- FSM states and transitions:
  - IDLE: ->HDR when FIFO non-empty.
  - HDR->ADDR->INSN on each handshake.
  - INSN: ->TVAL if has_tval; else ->HDR if FIFO has >1 entry, else ->IDLE.
  - TVAL: ->HDR if FIFO has >1 entry, else ->IDLE.
  - Back-to-back records produce no bubble.
- Outputs registered: tr_valid/tr_data/tr_last held stable while tr_valid & !tr_ready; advance only on handshake.
- Latency: packet captured in cycle N with empty FIFO gives header on tr_data in cycle N+1.
- trace_en deassertion stops capture only; records already queued or in flight complete normally.
- fifo_empty = FIFO empty & FSM IDLE.
- Full and empty flags use an extra pointer wrap bit; DEPTH entries are usable.

Decomposition:
- el2_pkg additions:
  - typedef el2_trace_rec_hdr_t (packed header fields above)
  - enum el2_trace_ser_state_t {IDLE,HDR,ADDR,INSN,TVAL}
  - localparam TRACE_DROP_SAT=63
- One natural sub-module: el2_trace_fifo. It is a parameterized synchronous FIFO with the same-cycle push-when-full-with-pop rule, storing {el2_trace_pkt_t, seq, pend_drop}.
- FSM and header build stay in the top module.

Test Plan:
- Single retire: trace_en=1, one cycle valid_ip=1, address=0x80000010, insn=0x00A00093, tr_ready=1 -> next cycle header 0x0000_0001, then 0x80000010, then 0x00A00093 with tr_last=1; fifo_empty returns 1.
- Exception record: exception_ip=1, ecause=2, tval=0xDEAD_BEEF, seq=0 at capture -> header 0x0000_0112, 4 words, tr_last only on 0xDEADBEEF.
- Backpressure: tr_ready=0 for 5 cycles mid-record -> tr_data/tr_valid constant throughout; resume on tr_ready=1 with no word lost or duplicated.
- Overflow: DEPTH=4, tr_ready=0, 7 consecutive valid packets -> 4 stored, drop_total=3; next accepted record header [14:9]=3, later records show 0.
- Full with simultaneous pop: FIFO full, last word handshake and new cap in the same cycle -> packet stored, no drop, drop_total unchanged.
- Reset mid-record: assert rst_l=0 after ADDR word -> tr_valid=0 asynchronously; after release, next packet header has seq=0 and drop_total=0.
